aurora_tx_arbiter: RTL and testbench

- Frame-granular round-robin arbiter sharing one Aurora TX AXI4-Stream user interface between two sources, e.g. the frame generator and the loopback buffer.
- Sits between the sources and the Aurora core TX port, in the USER_CLK domain of that Aurora instance.
- Never interleaves beats of different frames.
- Handles channel loss mid-frame by draining the granted source.

---
 rtl/aurora_tx_pkg.sv | 22 ++
 rtl/aurora_tx_frame_mon.sv | 62 ++++++
 rtl/aurora_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_aurora_tx_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_tx_pkg.sv
// Shared types and defaults for the Aurora TX frame arbiter.
// The optional per-source frame counters are controlled by AURORA_TX_ARB_STATS_EN.
package aurora_tx_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int MAX_BEATS_DEF = 256;
  localparam int CNT_W_DEF     = 16;
  localparam int KEEP_W_DEF    = DATA_W_DEF / 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT0 = 3'd1,
    ST_GRANT1 = 3'd2,
    ST_DRAIN0 = 3'd3,
    ST_DRAIN1 = 3'd4
  } arb_state_t;

  function automatic int keep_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/aurora_tx_frame_mon.sv
// Per-grant beat counter with sticky oversize flag and per-source frame counters.
// Frame counters exist only when AURORA_TX_ARB_STATS_EN is defined; otherwise they read 0.
module aurora_tx_frame_mon
  import aurora_tx_pkg::*;
#(
  parameter int MAX_BEATS = MAX_BEATS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_beat,
  input  logic             i_last,
  input  logic [1:0]       i_gnt,
  output logic             o_oversize,
  output logic [CNT_W-1:0] o_frame_cnt_0,
  output logic [CNT_W-1:0] o_frame_cnt_1
);

  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_oversize;

  // The count clears whenever no source holds the grant, so a drained frame leaves nothing behind.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat_cnt <= '0;
      r_oversize <= 1'b0;
    end else if (i_gnt == 2'b00) begin
      r_beat_cnt <= '0;
    end else if (i_beat) begin
      if (r_beat_cnt >= CNT_W'(MAX_BEATS))
        r_oversize <= 1'b1;
      if (i_last)
        r_beat_cnt <= '0;
      else if (r_beat_cnt != '1)
        r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  assign o_oversize = r_oversize;

`ifdef AURORA_TX_ARB_STATS_EN
  logic [CNT_W-1:0] r_frame_cnt_0;
  logic [CNT_W-1:0] r_frame_cnt_1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt_0 <= '0;
      r_frame_cnt_1 <= '0;
    end else if (i_beat && i_last) begin
      if (i_gnt[0]) r_frame_cnt_0 <= r_frame_cnt_0 + 1'b1;
      if (i_gnt[1]) r_frame_cnt_1 <= r_frame_cnt_1 + 1'b1;
    end
  end

  assign o_frame_cnt_0 = r_frame_cnt_0;
  assign o_frame_cnt_1 = r_frame_cnt_1;
`else
  assign o_frame_cnt_0 = '0;
  assign o_frame_cnt_1 = '0;
`endif

endmodule

// File: rtl/aurora_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one Aurora TX AXI4-Stream port between two sources.
// Define AURORA_TX_ARB_STATS_EN to build the completed-frame counters.
//
//   state  | meaning
//   IDLE   | no grant; picks the next requester while the channel is up
//   GRANT0 | source 0 mirrored onto the TX port
//   GRANT1 | source 1 mirrored onto the TX port
//   DRAIN0 | channel lost mid-frame; source 0 beats discarded until its TLAST
//   DRAIN1 | channel lost mid-frame; source 1 beats discarded until its TLAST
module aurora_tx_arbiter
  import aurora_tx_pkg::*;
#(
  parameter int  DATA_W    = DATA_W_DEF,
  parameter int  MAX_BEATS = MAX_BEATS_DEF,
  parameter int  CNT_W     = CNT_W_DEF,
  localparam int KEEP_W    = keep_w(DATA_W)
) (
  input  logic              USER_CLK,
  input  logic              RESET_N,
  input  logic              CHANNEL_UP,
  input  logic [DATA_W-1:0] S0_TDATA,
  input  logic [KEEP_W-1:0] S0_TKEEP,
  input  logic              S0_TLAST,
  input  logic              S0_TVALID,
  output logic              S0_TREADY,
  input  logic [DATA_W-1:0] S1_TDATA,
  input  logic [KEEP_W-1:0] S1_TKEEP,
  input  logic              S1_TLAST,
  input  logic              S1_TVALID,
  output logic              S1_TREADY,
  output logic [DATA_W-1:0] M_TDATA,
  output logic [KEEP_W-1:0] M_TKEEP,
  output logic              M_TLAST,
  output logic              M_TVALID,
  input  logic              M_TREADY,
  output logic [1:0]        GNT,
  output logic              OVERSIZE_ERR,
  output logic              DROP_ERR,
  output logic [CNT_W-1:0]  FRAME_CNT_0,
  output logic [CNT_W-1:0]  FRAME_CNT_1
);

  arb_state_t r_state;
  logic [1:0] r_gnt;
  logic       r_last_served;
  logic       r_drop_err;
  logic       w_m_accept;

  assign w_m_accept = M_TVALID & M_TREADY;

  // r_last_served = 1 means source 1 went last, so source 0 wins the first tie after reset.
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= ST_IDLE;
      r_gnt         <= 2'b00;
      r_last_served <= 1'b1;
      r_drop_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (CHANNEL_UP && (S0_TVALID || S1_TVALID)) begin
            if (S0_TVALID && (!S1_TVALID || r_last_served)) begin
              r_state <= ST_GRANT0;
              r_gnt   <= 2'b01;
            end else begin
              r_state <= ST_GRANT1;
              r_gnt   <= 2'b10;
            end
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (w_m_accept && M_TLAST) begin
            r_state       <= ST_IDLE;
            r_gnt         <= 2'b00;
            r_last_served <= (r_state == ST_GRANT1);
          end else if (!CHANNEL_UP) begin
            r_state    <= (r_state == ST_GRANT0) ? ST_DRAIN0 : ST_DRAIN1;
            r_drop_err <= 1'b1;
          end
        end
        ST_DRAIN0: begin
          if (S0_TVALID && S0_TLAST) begin
            r_state       <= ST_IDLE;
            r_gnt         <= 2'b00;
            r_last_served <= 1'b0;
          end
        end
        ST_DRAIN1: begin
          if (S1_TVALID && S1_TLAST) begin
            r_state       <= ST_IDLE;
            r_gnt         <= 2'b00;
            r_last_served <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 2'b00;
        end
      endcase
    end
  end

  // Zero-latency datapath: the granted source sees the core's TREADY directly.
  always_comb begin
    M_TDATA   = '0;
    M_TKEEP   = '0;
    M_TLAST   = 1'b0;
    M_TVALID  = 1'b0;
    S0_TREADY = 1'b0;
    S1_TREADY = 1'b0;
    case (r_state)
      ST_GRANT0: begin
        M_TDATA   = S0_TDATA;
        M_TKEEP   = S0_TKEEP;
        M_TLAST   = S0_TLAST;
        M_TVALID  = S0_TVALID;
        S0_TREADY = M_TREADY;
      end
      ST_GRANT1: begin
        M_TDATA   = S1_TDATA;
        M_TKEEP   = S1_TKEEP;
        M_TLAST   = S1_TLAST;
        M_TVALID  = S1_TVALID;
        S1_TREADY = M_TREADY;
      end
      ST_DRAIN0: S0_TREADY = 1'b1;
      ST_DRAIN1: S1_TREADY = 1'b1;
      default: ;
    endcase
  end

  assign GNT      = r_gnt;
  assign DROP_ERR = r_drop_err;

  aurora_tx_frame_mon #(
    .MAX_BEATS (MAX_BEATS),
    .CNT_W     (CNT_W)
  ) u_frame_mon (
    .i_clk         (USER_CLK),
    .i_rst_n       (RESET_N),
    .i_beat        (w_m_accept),
    .i_last        (M_TLAST),
    .i_gnt         (r_gnt),
    .o_oversize    (OVERSIZE_ERR),
    .o_frame_cnt_0 (FRAME_CNT_0),
    .o_frame_cnt_1 (FRAME_CNT_1)
  );

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Self-checking bench for aurora_tx_arbiter against a frame-level reference model.
// Expected frame counts follow AURORA_TX_ARB_STATS_EN (zero when the macro is undefined).
module tb_aurora_tx_arbiter;
  import aurora_tx_pkg::*;

  localparam int DW   = 32;
  localparam int KW   = KEEP_W_DEF;
  localparam int MAXB = 256;
  localparam int CW   = 16;
`ifdef AURORA_TX_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          USER_CLK, RESET_N, CHANNEL_UP;
  logic [DW-1:0] S0_TDATA, S1_TDATA, M_TDATA;
  logic [KW-1:0] S0_TKEEP, S1_TKEEP, M_TKEEP;
  logic          S0_TLAST, S0_TVALID, S0_TREADY;
  logic          S1_TLAST, S1_TVALID, S1_TREADY;
  logic          M_TLAST, M_TVALID, M_TREADY;
  logic [1:0]    GNT;
  logic          OVERSIZE_ERR, DROP_ERR;
  logic [CW-1:0] FRAME_CNT_0, FRAME_CNT_1;

  aurora_tx_arbiter #(.DATA_W(DW), .MAX_BEATS(MAXB), .CNT_W(CW)) dut (
    .USER_CLK(USER_CLK), .RESET_N(RESET_N), .CHANNEL_UP(CHANNEL_UP),
    .S0_TDATA(S0_TDATA), .S0_TKEEP(S0_TKEEP), .S0_TLAST(S0_TLAST),
    .S0_TVALID(S0_TVALID), .S0_TREADY(S0_TREADY),
    .S1_TDATA(S1_TDATA), .S1_TKEEP(S1_TKEEP), .S1_TLAST(S1_TLAST),
    .S1_TVALID(S1_TVALID), .S1_TREADY(S1_TREADY),
    .M_TDATA(M_TDATA), .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY),
    .GNT(GNT), .OVERSIZE_ERR(OVERSIZE_ERR), .DROP_ERR(DROP_ERR),
    .FRAME_CNT_0(FRAME_CNT_0), .FRAME_CNT_1(FRAME_CNT_1)
  );

  initial begin
    USER_CLK = 1'b0;
    forever #5 USER_CLK = ~USER_CLK;
  end

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int    order[$];
  int    errors = 0;
  int    checks = 0;

  // Reference model: phase 0 = no grant, 1 = forwarding msrc, 2 = discarding msrc.
  int ph, msrc, bc, run_beats;
  bit ls, e_ovf, e_drop;
  int e_fc0, e_fc1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0; msrc = 0; bc = 0; ls = 1'b1;
    e_ovf = 1'b0; e_drop = 1'b0; e_fc0 = 0; e_fc1 = 0;
  endtask

  task automatic add_frame(input int src, input int len, input bit seq);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = seq ? DW'(i + 1) : DW'($urandom);
      b.keep = seq ? {KW{1'b1}} : KW'($urandom);
      b.last = (i == len - 1);
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  task automatic drive(input bit chan, input bit trdy);
    CHANNEL_UP = chan;
    M_TREADY   = chan & trdy;
    if (q0.size() > 0) begin
      S0_TVALID = 1'b1; S0_TDATA = q0[0].data; S0_TKEEP = q0[0].keep; S0_TLAST = q0[0].last;
    end else begin
      S0_TVALID = 1'b0; S0_TDATA = '0; S0_TKEEP = '0; S0_TLAST = 1'b0;
    end
    if (q1.size() > 0) begin
      S1_TVALID = 1'b1; S1_TDATA = q1[0].data; S1_TKEEP = q1[0].keep; S1_TLAST = q1[0].last;
    end else begin
      S1_TVALID = 1'b0; S1_TDATA = '0; S1_TKEEP = '0; S1_TLAST = 1'b0;
    end
  endtask

  task automatic cycle(input bit chan, input bit trdy);
    beat_t h;
    bit    hs0, hs1, m_rdy;
    m_rdy = chan & trdy;
    drive(chan, trdy);
    @(negedge USER_CLK);
    h = '{data: '0, keep: '0, last: 1'b0};
    if (msrc == 0 && q0.size() > 0) h = q0[0];
    if (msrc == 1 && q1.size() > 0) h = q1[0];
    if (ph == 0) begin
      chk("idle_gnt", GNT, 0);
      chk("idle_mvalid", M_TVALID, 0);
      chk("idle_ready", {S0_TREADY, S1_TREADY}, 0);
    end else begin
      chk("gnt", GNT, (msrc == 0) ? 1 : 2);
      if (ph == 1) begin
        chk("m_tvalid", M_TVALID, 1);
        chk("m_tdata", M_TDATA, h.data);
        chk("m_tkeep", M_TKEEP, h.keep);
        chk("m_tlast", M_TLAST, h.last);
        chk("src_tready", (msrc == 0) ? S0_TREADY : S1_TREADY, m_rdy);
        chk("other_tready", (msrc == 0) ? S1_TREADY : S0_TREADY, 0);
      end else begin
        chk("drain_mvalid", M_TVALID, 0);
        chk("drain_tready", (msrc == 0) ? S0_TREADY : S1_TREADY, 1);
        chk("drain_other", (msrc == 0) ? S1_TREADY : S0_TREADY, 0);
      end
    end
    chk("oversize_err", OVERSIZE_ERR, e_ovf);
    chk("drop_err", DROP_ERR, e_drop);
    chk("frame_cnt_0", FRAME_CNT_0, STATS ? e_fc0 : 0);
    chk("frame_cnt_1", FRAME_CNT_1, STATS ? e_fc1 : 0);
    hs0 = S0_TVALID & S0_TREADY;
    hs1 = S1_TVALID & S1_TREADY;
    @(posedge USER_CLK);
    #1;
    case (ph)
      0: if (chan && (q0.size() > 0 || q1.size() > 0)) begin
        if (q0.size() > 0 && q1.size() > 0) msrc = ls ? 0 : 1;
        else                                 msrc = (q0.size() > 0) ? 0 : 1;
        ph = 1; bc = 0;
        order.push_back(msrc);
      end
      1: if (m_rdy) begin
        bc++; run_beats++;
        if (bc > MAXB) e_ovf = 1'b1;
        if (h.last) begin
          ls = (msrc == 1); ph = 0;
          if (msrc == 0) e_fc0++; else e_fc1++;
        end
      end else if (!chan) begin
        ph = 2; e_drop = 1'b1;
      end
      default: if (h.last) begin
        ls = (msrc == 1); ph = 0;
      end
    endcase
    if (hs0) void'(q0.pop_front());
    if (hs1) void'(q1.pop_front());
  endtask

  // tmode: 0 = TREADY always 1, 1 = alternating 1/0, 2 = random.
  task automatic run(input int tmode, input int drop_at, input int maxcyc, input bit need_done);
    int cyc = 0;
    int dcnt = 0;
    bit ddone = 1'b0;
    bit tr;
    run_beats = 0;
    while (cyc < maxcyc && !(ph == 0 && q0.size() == 0 && q1.size() == 0)) begin
      case (tmode)
        0:       tr = 1'b1;
        1:       tr = ((cyc % 2) == 0);
        default: tr = ($urandom_range(0, 1) == 1);
      endcase
      cycle(dcnt == 0, tr);
      if (dcnt > 0) dcnt--;
      if (drop_at > 0 && !ddone && run_beats == drop_at) begin
        dcnt = 2; ddone = 1'b1;
      end
      cyc++;
    end
    if (need_done) begin
      chk("run_done", (ph == 0 && q0.size() == 0 && q1.size() == 0), 1);
      cycle(1'b1, 1'b1);
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    q0.delete(); q1.delete();
    drive(1'b1, 1'b1);
    repeat (2) @(posedge USER_CLK);
    @(negedge USER_CLK);
    RESET_N = 1'b1;
    @(posedge USER_CLK);
    #1;
    model_reset();
    order.delete();
  endtask

  initial begin
    RESET_N = 1'b0;
    model_reset();
    do_reset();
    chk("reset_gnt", GNT, 0);
    chk("reset_errs", {OVERSIZE_ERR, DROP_ERR}, 0);

    // Single source, sequential data, zero-latency mirror.
    add_frame(0, 4, 1'b1);
    run(0, 0, 100, 1'b1);
    chk("t1_frame_cnt_0", FRAME_CNT_0, STATS ? 1 : 0);

    // Both sources from reset: alternation starting with source 0, single-beat frame included.
    do_reset();
    add_frame(0, 1, 1'b0);
    add_frame(0, $urandom_range(2, 5), 1'b0);
    add_frame(1, $urandom_range(1, 5), 1'b0);
    add_frame(1, $urandom_range(1, 5), 1'b0);
    run(0, 0, 200, 1'b1);
    chk("t2_frames", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk("t2_order", order[i], i % 2);

    // Back-pressure alternating during a 6-beat source 1 frame.
    add_frame(1, 6, 1'b0);
    run(1, 0, 100, 1'b1);
    chk("t3_frame_cnt_1", FRAME_CNT_1, STATS ? 3 : 0);

    // Channel loss after beat 2 of an 8-beat source 0 frame.
    add_frame(0, 8, 1'b0);
    run(0, 2, 100, 1'b1);
    chk("t4_drop_err", DROP_ERR, 1);
    chk("t4_frame_cnt_0", FRAME_CNT_0, STATS ? 2 : 0);

    // Oversize frame on source 1 with random back-pressure.
    add_frame(1, 258, 1'b0);
    run(2, 0, 2000, 1'b1);
    chk("t5_oversize", OVERSIZE_ERR, 1);
    chk("t5_frame_cnt_1", FRAME_CNT_1, STATS ? 4 : 0);

    // Random mix of frames from both sources.
    for (int i = 0; i < 8; i++)
      add_frame($urandom_range(0, 1), $urandom_range(1, 12), 1'b0);
    run(2, 0, 1000, 1'b1);

    // Asynchronous reset in the middle of a frame.
    add_frame(1, 20, 1'b0);
    run(0, 0, 5, 1'b0);
    chk("t7_pre_gnt", GNT, 2);
    #1 RESET_N = 1'b0;
    #1;
    chk("t7_rst_gnt", GNT, 0);
    chk("t7_rst_mvalid", M_TVALID, 0);
    chk("t7_rst_oversize", OVERSIZE_ERR, 0);
    chk("t7_rst_drop", DROP_ERR, 0);
    do_reset();
    add_frame(1, 3, 1'b0);
    run(2, 0, 100, 1'b1);
    chk("t7_frame_cnt_1", FRAME_CNT_1, STATS ? 1 : 0);
    chk("t7_frame_cnt_0", FRAME_CNT_0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
